// File: rtl/sample_matrix_ctrl_pkg.sv
// Shared constants for the matrix sampling controller: lane count, per-level
// element totals, derived beat counts and last-beat lane counts, FSM states.
package sample_matrix_ctrl_pkg;

  localparam int PARALLEL_NUM = 28;

  localparam int TOTAL_L0 = 5120;
  localparam int TOTAL_L1 = 7808;
  localparam int TOTAL_L2 = 10752;

  localparam logic [1:0] LVL_ILLEGAL = 2'b11;

  function automatic int beats_for(input int total, input int lanes);
    return (total + lanes - 32'sd1) / lanes;
  endfunction

  function automatic int last_lanes(input int total, input int lanes);
    return total % lanes;
  endfunction

  localparam int BEATS_L0 = beats_for(TOTAL_L0, PARALLEL_NUM);
  localparam int BEATS_L1 = beats_for(TOTAL_L1, PARALLEL_NUM);
  localparam int BEATS_L2 = beats_for(TOTAL_L2, PARALLEL_NUM);

  localparam int LAST_L0 = last_lanes(TOTAL_L0, PARALLEL_NUM);
  localparam int LAST_L1 = last_lanes(TOTAL_L1, PARALLEL_NUM);
  localparam int LAST_L2 = last_lanes(TOTAL_L2, PARALLEL_NUM);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sample_matrix_ctrl_beat_cnt.sv
// Beat counter for one matrix: tracks accepted beats, flags the final beat and
// builds the lane mask (partial only on a final beat that does not fill all lanes).
module sm_beat_cnt
  import sample_matrix_ctrl_pkg::*;
#(
  parameter int PN     = sample_matrix_ctrl_pkg::PARALLEL_NUM,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  input  logic [1:0]        lvl,
  output logic [ADDR_W-1:0] cnt,
  output logic              remain,
  output logic              is_last,
  output logic [PN-1:0]     mask
);

  logic [ADDR_W-1:0] beats_s;
  int                lanes_s;

  function automatic logic [PN-1:0] low_lanes(input int lanes);
    logic [PN-1:0] m;
    m = '0;
    for (int i = 0; i < PN; i++) begin
      m[i] = (i < lanes) ? 1'b1 : 1'b0;
    end
    return m;
  endfunction

  // Per-level beat count and number of lanes used by the last beat
  always_comb begin
    beats_s = '0;
    lanes_s = 0;
    case (lvl)
      2'b00:   begin beats_s = ADDR_W'(beats_for(TOTAL_L0, PN)); lanes_s = last_lanes(TOTAL_L0, PN); end
      2'b01:   begin beats_s = ADDR_W'(beats_for(TOTAL_L1, PN)); lanes_s = last_lanes(TOTAL_L1, PN); end
      2'b10:   begin beats_s = ADDR_W'(beats_for(TOTAL_L2, PN)); lanes_s = last_lanes(TOTAL_L2, PN); end
      default: begin beats_s = '0; lanes_s = 0; end
    endcase
  end

  // Status and lane mask for the beat about to be accepted
  always_comb begin
    remain  = (cnt < beats_s);
    is_last = remain && (cnt == (beats_s - {{(ADDR_W-1){1'b0}}, 1'b1}));
    if (is_last && (lanes_s != 0)) begin
      mask = low_lanes(lanes_s);
    end else begin
      mask = '1;
    end
  end

  // Accepted-beat counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      cnt <= cnt;
    end
  end

endmodule

// File: rtl/sample_matrix_ctrl.sv
// Streams random beats through an external sampler and writes the masked
// results to a sequentially addressed sink, one matrix per start request.
module sample_matrix_ctrl
  import sample_matrix_ctrl_pkg::*;
#(
  parameter int PARALLEL_NUM = sample_matrix_ctrl_pkg::PARALLEL_NUM,
  parameter int ADDR_W       = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                sec_lvl,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  input  logic [16*PARALLEL_NUM-1:0] rnd_data,
  input  logic                      rnd_valid,
  output logic                      rnd_ready,
  output logic [16*PARALLEL_NUM-1:0] sm_in_set,
  output logic [1:0]                sm_sec_lvl,
  input  logic [16*PARALLEL_NUM-1:0] sm_out_set,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [16*PARALLEL_NUM-1:0] wr_data,
  output logic [PARALLEL_NUM-1:0]   wr_mask,
  input  logic                      wr_ready
);

  localparam int DW = 16 * PARALLEL_NUM;

  state_e                  state_r;
  state_e                  state_nx_s;
  logic [1:0]              lvl_r;
  logic                    err_r;
  logic                    accept_s;
  logic                    launch_s;
  logic [ADDR_W-1:0]       cnt_s;
  logic                    remain_s;
  logic                    is_last_s;
  logic [PARALLEL_NUM-1:0] mask_s;
  logic [DW-1:0]           masked_s;

  sm_beat_cnt #(
    .PN     (PARALLEL_NUM),
    .ADDR_W (ADDR_W)
  ) u_beat_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (launch_s),
    .inc     (accept_s),
    .lvl     (lvl_r),
    .cnt     (cnt_s),
    .remain  (remain_s),
    .is_last (is_last_s),
    .mask    (mask_s)
  );

  assign sm_in_set  = rnd_data;
  assign sm_sec_lvl = lvl_r;
  assign launch_s   = (state_r == ST_IDLE) && start;
  assign rnd_ready  = (state_r == ST_RUN) && (!wr_en || wr_ready) && remain_s;
  assign accept_s   = rnd_valid && rnd_ready;
  assign busy       = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign done       = (state_r == ST_DONE);
  assign err        = err_r;

  // Zero the sampler lanes that fall beyond the matrix on the final beat
  always_comb begin
    masked_s = '0;
    for (int i = 0; i < PARALLEL_NUM; i++) begin
      if (mask_s[i]) begin
        masked_s[16*i +: 16] = sm_out_set[16*i +: 16];
      end else begin
        masked_s[16*i +: 16] = 16'h0000;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nx_s = (sec_lvl == LVL_ILLEGAL) ? ST_DONE : ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (accept_s && is_last_s) begin
          state_nx_s = ST_DRAIN;
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (wr_en && wr_ready) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  // State, latched level and error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      lvl_r   <= 2'b00;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (launch_s) begin
        lvl_r <= sec_lvl;
        err_r <= (sec_lvl == LVL_ILLEGAL);
      end else begin
        lvl_r <= lvl_r;
        err_r <= err_r;
      end
    end
  end

  // Single-entry output register; a completing write and a new beat swap in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_mask <= '0;
    end else if (accept_s) begin
      wr_en   <= 1'b1;
      wr_addr <= cnt_s;
      wr_data <= masked_s;
      wr_mask <= mask_s;
    end else if (wr_en && wr_ready) begin
      wr_en   <= 1'b0;
      wr_addr <= wr_addr;
      wr_data <= wr_data;
      wr_mask <= wr_mask;
    end else begin
      wr_en   <= wr_en;
      wr_addr <= wr_addr;
      wr_data <= wr_data;
      wr_mask <= wr_mask;
    end
  end

endmodule

// File: doc/sample_matrix_ctrl.md
SAMPLE_MATRIX_CTRL -- requirements
Module: sample_matrix_ctrl

Interface
REQ-001 SHALL have parameter PARALLEL_NUM, default 28: number of 16-bit lanes per beat.
REQ-002 SHALL have parameter ADDR_W, default 9: width of the output beat address.
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports:
- start  in  1  one-cycle request to sample one matrix.
- sec_lvl  in  2  00/01/10 select the parameter set; 11 is illegal.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; set for an illegal sec_lvl.
REQ-005 SHALL have ports:
- rnd_data  in  16*PARALLEL_NUM  random beat.
- rnd_valid  in  1  random beat valid.
- rnd_ready  out  1  random beat accepted.
REQ-006 SHALL have ports:
- sm_in_set  out  16*PARALLEL_NUM  drives the sampler input.
- sm_sec_lvl  out  2  drives the sampler sec_lvl.
- sm_out_set  in  16*PARALLEL_NUM  sampler result (combinational).
REQ-007 SHALL have ports:
- wr_en  out  1  write strobe.
- wr_addr  out  ADDR_W  beat address.
- wr_data  out  16*PARALLEL_NUM  samples.
- wr_mask  out  PARALLEL_NUM  lane-valid bits.
- wr_ready  in  1  sink accepts the write.

Function
REQ-008 SHALL implement the FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
REQ-009 SHALL, in IDLE on start, latch sec_lvl and clear the beat counter; for sec_lvl=11 it SHALL go straight to DONE with err=1 and no writes.
REQ-010 SHALL sample the element totals 5120, 7808 and 10752 for sec_lvl 00, 01 and 10, giving 183, 279 and 384 beats.
REQ-011 SHALL drive sm_in_set=rnd_data and sm_sec_lvl=latched level combinationally, and capture sm_out_set into the output register when a beat is accepted.
REQ-012 SHALL assert rnd_ready only in RUN, and only when (!wr_en || wr_ready) and beats remain.
REQ-013 SHALL accept a random beat when rnd_valid && rnd_ready.
REQ-014 SHALL present a beat accepted at cycle t on wr_en/wr_addr/wr_data/wr_mask at t+1, giving latency 1.
REQ-015 SHALL hold wr_* stable while wr_en && !wr_ready.
REQ-016 SHALL assign wr_addr sequentially from 0 up to beats-1, with no wrap.
REQ-017 SHALL drive wr_mask all-ones except on the final beat when the element total mod PARALLEL_NUM != 0; the final beat SHALL then carry only the low (total mod PARALLEL_NUM) bits set, i.e. 24 lanes, 0x0FFFFFF, for levels 00 and 01.
REQ-018 SHALL zero wr_data lanes whose mask bit is 0.
REQ-019 SHALL enter DRAIN after the last beat is accepted, and leave DRAIN for DONE when the last write completes (wr_en && wr_ready).
REQ-020 SHALL pulse done for exactly one cycle in DONE, then return to IDLE.
REQ-021 SHALL deassert busy in the same cycle that done is asserted.
REQ-022 SHALL ignore start while busy.
REQ-023 SHALL make start asserted in the done cycle take effect only in the following cycle (from IDLE).
REQ-024 SHALL, in the cycle where a write completes and a new beat is accepted together, replace the register contents with no bubble.
REQ-025 SHALL leave a sec_lvl change while busy without effect.

Reset
REQ-026 SHALL on rst drive state=IDLE, busy=0, done=0, err=0, rnd_ready=0, wr_en=0, wr_addr=0, wr_data=0, wr_mask=0 and beat counter=0.
REQ-027 SHALL on rst mid-operation abort at once with no done pulse, and a later start SHALL restart from address 0.

Structure
REQ-028 SHALL take from a shared package:
- PARALLEL_NUM.
- the per-level element totals and beat counts.
- the last-beat mask widths.
- the FSM state enum.
REQ-029 SHALL leave the sampler datapath outside this module, connected through the sm_* ports.
REQ-030 SHALL allow one sub-module, sm_beat_cnt, holding the beat counter, last-beat flag and mask generation.

Verification
REQ-031 SHALL cover: sec_lvl=00 with rnd_valid held high and wr_ready=1 -> 183 writes at addresses 0..182, the last with mask 0x0FFFFFF, then done 1 cycle after the last write.
REQ-032 SHALL cover: sec_lvl=10 with rnd_valid toggling every other cycle -> 384 writes, all masks 0xFFFFFFF, and done with err=0.
REQ-033 SHALL cover: sec_lvl=01 with wr_ready low for 5 cycles at beat 100 -> rnd_ready=0 and wr_* stable for those cycles, 279 writes, no loss or duplication.
REQ-034 SHALL cover: sec_lvl=11 -> done and err=1 within 2 cycles, with zero writes and zero rnd_ready.
REQ-035 SHALL cover: rst asserted at beat 50 -> all outputs at reset values in the same cycle, and a following sec_lvl=00 start -> the first write at address 0.
REQ-036 SHALL cover: start pulsed mid-run -> ignored, with exactly one done pulse.
